// File: rtl/cic_integ_decim.sv
// CIC integrator section with decimation. A cascade of STAGES wrapping
// integrators runs at the input sample rate; every R = rate+1 valid samples
// the top bits of the last integrator are presented to the downstream comb
// together with a one-cycle active-low hold strobe.
module cic_integ_decim #(
  parameter int IN_WIDTH  = 8,
  parameter int STAGES    = 3,
  parameter int RATE_BITS = 4,
  parameter int OUT_WIDTH = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic signed [IN_WIDTH-1:0]  data_in,
  input  logic [RATE_BITS-1:0]        rate,
  output logic signed [OUT_WIDTH-1:0] data_out,
  output logic                        hold,
  output logic                        rate_err
);

  // Growth of STAGES * log2(R_max) bits keeps the wrapped integrators exact
  // as seen through the downstream comb.
  localparam int ACC_W = IN_WIDTH + STAGES * RATE_BITS;

  logic signed [ACC_W-1:0]     acc_q [STAGES];
  logic signed [ACC_W-1:0]     acc_d [STAGES];
  logic [RATE_BITS-1:0]        cnt_q, cnt_d;
  logic [RATE_BITS-1:0]        rate_q, rate_d;
  logic signed [OUT_WIDTH-1:0] data_out_q, data_out_d;
  logic                        hold_q, hold_d;
  logic                        rate_err_q, rate_err_d;
  logic                        wrap;

  function automatic logic signed [ACC_W-1:0] sext_in(
    input logic signed [IN_WIDTH-1:0] x
  );
    return {{(ACC_W-IN_WIDTH){x[IN_WIDTH-1]}}, x};
  endfunction

  // Plain truncation: keep the MSBs, drop the LSBs, no rounding.
  function automatic logic signed [OUT_WIDTH-1:0] out_slice(
    input logic signed [ACC_W-1:0] a
  );
    return a[ACC_W-1 -: OUT_WIDTH];
  endfunction

  // Next-state: integrator cascade, frame counter, output capture, rate tracking
  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    rate_d     = rate_q;
    data_out_d = data_out_q;
    wrap       = in_valid && (cnt_q == rate_q);
    hold_d     = !wrap;
    rate_err_d = rate_err_q | ((rate != rate_q) && (cnt_q != '0));

    if (in_valid) begin
      // Each stage adds the previous stage's registered value, giving one
      // cycle of pipeline per stage.
      acc_d[0] = acc_q[0] + sext_in(data_in);
      for (int k = 1; k < STAGES; k++) begin
        acc_d[k] = acc_q[k] + acc_q[k-1];
      end
      cnt_d = cnt_q + RATE_BITS'(1);
    end

    if (wrap) begin
      cnt_d      = '0;
      rate_d     = rate;
      data_out_d = out_slice(acc_d[STAGES-1]);
    end
  end

  // State registers; reset discards any partial frame and relatches rate
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        acc_q[k] <= '0;
      end
      cnt_q      <= '0;
      rate_q     <= rate;
      data_out_q <= '0;
      hold_q     <= 1'b1;
      rate_err_q <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        acc_q[k] <= acc_d[k];
      end
      cnt_q      <= cnt_d;
      rate_q     <= rate_d;
      data_out_q <= data_out_d;
      hold_q     <= hold_d;
      rate_err_q <= rate_err_d;
    end
  end

  assign data_out = data_out_q;
  assign hold     = hold_q;
  assign rate_err = rate_err_q;

endmodule

// File: tb/tb_cic_integ_decim.sv
// Bench for cic_integ_decim: a single-stage 12-bit instance and a three-stage
// full-width instance, driven with directed vectors. Expected outputs are
// queued at stimulus time and popped by a monitor whenever hold goes low;
// status expectations are queued and checked by the same monitor.
module tb_cic_integ_decim;

  typedef struct {
    int          dut;
    int          sig;
    logic [19:0] val;
    string       name;
  } stat_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Single-stage instance: ACC_W = 12, output is the whole accumulator
  logic              reset1, in_valid1;
  logic signed [7:0] data1;
  logic [3:0]        rate1;
  logic [11:0]       data_out1;
  logic              hold1, err1;

  // Three-stage instance: ACC_W = 20, output is the whole accumulator
  logic              reset3, in_valid3;
  logic signed [7:0] data3;
  logic [3:0]        rate3;
  logic [19:0]       data_out3;
  logic              hold3, err3;

  logic [19:0] q1[$];
  logic [19:0] q3[$];
  stat_t       sq[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        done    = 1'b0;
  logic        fin     = 1'b0;

  cic_integ_decim #(
    .IN_WIDTH(8), .STAGES(1), .RATE_BITS(4), .OUT_WIDTH(12)
  ) u_s1 (
    .clock(clock), .reset(reset1), .in_valid(in_valid1), .data_in(data1),
    .rate(rate1), .data_out(data_out1), .hold(hold1), .rate_err(err1)
  );

  cic_integ_decim #(
    .IN_WIDTH(8), .STAGES(3), .RATE_BITS(4), .OUT_WIDTH(20)
  ) u_s3 (
    .clock(clock), .reset(reset3), .in_valid(in_valid3), .data_in(data3),
    .rate(rate3), .data_out(data_out3), .hold(hold3), .rate_err(err3)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send1(input logic v, input logic signed [7:0] d);
    in_valid1 = v;
    data1     = d;
    tick();
    in_valid1 = 1'b0;
  endtask

  task automatic send3(input logic v, input logic signed [7:0] d);
    in_valid3 = v;
    data3     = d;
    tick();
    in_valid3 = 1'b0;
  endtask

  task automatic do_reset1(input logic [3:0] r);
    reset1    = 1'b1;
    in_valid1 = 1'b0;
    rate1     = r;
    tick();
    reset1    = 1'b0;
  endtask

  // sig: 0 = data_out, 1 = hold, 2 = rate_err
  task automatic stat(input int dut, input int sig, input logic [19:0] val,
                      input string name);
    stat_t s;
    s.dut  = dut;
    s.sig  = sig;
    s.val  = val;
    s.name = name;
    sq.push_back(s);
  endtask

  // Monitor: pop expected samples on each hold-low cycle, check queued status
  always @(negedge clock) begin
    logic [19:0] e;
    logic [19:0] act;
    stat_t       s;
    if (hold1 === 1'b0) begin
      n_tests++;
      if (q1.size() == 0) begin
        n_fail++;
        $display("FAIL s1_out: unexpected output %0h, required no output", data_out1);
      end else begin
        e = q1.pop_front();
        if ({8'd0, data_out1} !== e) begin
          n_fail++;
          $display("FAIL s1_out: got %0h, required %0h", data_out1, e);
        end
      end
    end
    if (hold3 === 1'b0) begin
      n_tests++;
      if (q3.size() == 0) begin
        n_fail++;
        $display("FAIL s3_out: unexpected output %0h, required no output", data_out3);
      end else begin
        e = q3.pop_front();
        if (data_out3 !== e) begin
          n_fail++;
          $display("FAIL s3_out: got %0h, required %0h", data_out3, e);
        end
      end
    end
    while (sq.size() > 0) begin
      s = sq.pop_front();
      case ({s.dut == 3, s.sig[1:0]})
        3'b000:  act = {8'd0, data_out1};
        3'b001:  act = {19'd0, hold1};
        3'b010:  act = {19'd0, err1};
        3'b100:  act = data_out3;
        3'b101:  act = {19'd0, hold3};
        default: act = {19'd0, err3};
      endcase
      n_tests++;
      if (act !== s.val) begin
        n_fail++;
        $display("FAIL %s: got %0h, required %0h", s.name, act, s.val);
      end
    end
    if (done && !fin) begin
      n_tests += 2;
      if (q1.size() != 0) begin
        n_fail++;
        $display("FAIL s1_pending: got %0d outputs still awaited, required 0", q1.size());
      end
      if (q3.size() != 0) begin
        n_fail++;
        $display("FAIL s3_pending: got %0d outputs still awaited, required 0", q3.size());
      end
      fin <= 1'b1;
    end
  end

  initial begin
    logic signed [7:0] e_d [4];
    logic [19:0]       e_o [2];
    logic [19:0]       f_exp [6];
    e_d   = '{8'sd5, -8'sd3, 8'sd7, 8'sd2};
    e_o   = '{20'd2, 20'd11};
    f_exp = '{20'd0, 20'd0, 20'd1, 20'd3, 20'd6, 20'd10};

    reset1 = 1'b1; in_valid1 = 1'b0; data1 = '0; rate1 = 4'd3;
    reset3 = 1'b1; in_valid3 = 1'b0; data3 = '0; rate3 = 4'd0;
    tick();
    tick();
    reset1 = 1'b0;
    reset3 = 1'b0;
    stat(1, 0, 20'd0, "rst_s1_data_out");
    stat(1, 1, 20'd1, "rst_s1_hold");
    stat(1, 2, 20'd0, "rst_s1_rate_err");
    stat(3, 0, 20'd0, "rst_s3_data_out");
    stat(3, 1, 20'd1, "rst_s3_hold");
    stat(3, 2, 20'd0, "rst_s3_rate_err");
    tick();

    // R = 4, constant 1: outputs 4, 8, 12
    do_reset1(4'd3);
    for (int i = 0; i < 12; i++) begin
      if (i % 4 == 3) q1.push_back(20'((i / 4 + 1) * 4));
      send1(1'b1, 8'sd1);
    end
    stat(1, 2, 20'd0, "A_rate_err");
    tick();

    // R = 16, constant -128: 12-bit wrap gives 0x800, 0x000, 0x800
    do_reset1(4'd15);
    for (int i = 0; i < 48; i++) begin
      if (i % 16 == 15) q1.push_back(((i / 16) % 2 == 0) ? 20'h800 : 20'h000);
      send1(1'b1, 8'sh80);
    end
    stat(1, 2, 20'd0, "B_rate_err");
    tick();

    // Rate 3 -> 7 mid-frame: frame of 4 ends at 4, next frame of 8 ends at 12
    do_reset1(4'd3);
    send1(1'b1, 8'sd1);
    send1(1'b1, 8'sd1);
    rate1 = 4'd7;
    send1(1'b1, 8'sd1);
    q1.push_back(20'd4);
    send1(1'b1, 8'sd1);
    stat(1, 2, 20'd1, "C_rate_err_set");
    for (int i = 0; i < 8; i++) begin
      if (i == 7) q1.push_back(20'd12);
      send1(1'b1, 8'sd1);
    end
    stat(1, 2, 20'd1, "C_rate_err_sticky");
    tick();

    // Reset after 2 of 4 samples, with in_valid high during reset
    do_reset1(4'd3);
    send1(1'b1, 8'sd1);
    send1(1'b1, 8'sd1);
    reset1    = 1'b1;
    in_valid1 = 1'b1;
    data1     = 8'sd5;
    tick();
    reset1    = 1'b0;
    in_valid1 = 1'b0;
    stat(1, 0, 20'd0, "D_data_out_after_rst");
    stat(1, 1, 20'd1, "D_hold_after_rst");
    stat(1, 2, 20'd0, "D_rate_err_after_rst");
    for (int i = 0; i < 4; i++) begin
      if (i == 3) q1.push_back(20'd4);
      send1(1'b1, 8'sd1);
    end
    tick();

    // R = 2 with idle cycles between samples carrying junk data
    do_reset1(4'd1);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 1) q1.push_back(e_o[i / 2]);
      send1(1'b1, e_d[i]);
      send1(1'b0, 8'sd100);
      if (i == 1) begin
        stat(1, 0, 20'd2, "E_idle_data_out");
        stat(1, 1, 20'd1, "E_idle_hold");
      end
    end
    stat(1, 0, 20'd11, "E_final_data_out");
    stat(1, 2, 20'd0, "E_rate_err");
    tick();

    // Three stages, R = 1, impulse: back-to-back outputs 0, 0, 1, 3, 6, 10
    reset3 = 1'b1;
    tick();
    reset3 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      q3.push_back(f_exp[i]);
      send3(1'b1, (i == 0) ? 8'sd1 : 8'sd0);
      if (i == 2) stat(3, 1, 20'd0, "F_hold_b2b");
    end
    send3(1'b0, 8'sd0);
    stat(3, 1, 20'd1, "F_hold_idle");
    stat(3, 0, 20'd10, "F_data_out_held");
    stat(3, 2, 20'd0, "F_rate_err");
    tick();
    tick();

    done = 1'b1;
    for (int i = 0; i < 10 && !fin; i++) tick();
    if (!fin) begin
      $display("FAIL final_check: monitor did not complete, required completion");
      $fatal(1, "final check timed out");
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
